// File: rtl/xor_shift_decoder.sv
// Keyed XOR/shift byte decoder: recovers plaintext from an encoded stream,
// flags integrity violations and queues results in a small output FIFO.
module xor_shift_decoder #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  input  logic [7:0] key_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_shift,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_err,
  output logic [7:0] ok_cnt,
  output logic [7:0] err_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    KEY_WAIT = 1'b0,
    RUN      = 1'b1
  } state_t;

  // Returns {err, plaintext}; the shifted path carries the integrity bit in C[0].
  function automatic logic [8:0] decode_byte(input logic [7:0] c,
                                             input logic [7:0] k,
                                             input logic       shift);
    logic [7:0] a;
    logic       err;
    if (shift) begin
      a   = {1'b1, c[7:1] ^ k[6:0]};
      err = c[0];
    end else begin
      a   = c ^ k;
      err = a[7];
    end
    return {err, a};
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [8:0]      mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_err_q, out_err_d;
  logic [7:0]      ok_cnt_q, ok_cnt_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            push_s, pop_s;
  logic [8:0]      dec_s, head_s;

  // Next-state, FIFO bookkeeping, counters and next registered outputs.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    head_s      = 9'h000;
    push_s      = in_valid && in_ready_q;
    pop_s       = out_valid_q && out_ready;
    dec_s       = decode_byte(in_data, key_q, in_shift);

    case (state_q)
      KEY_WAIT: begin
        if (key_load) state_d = RUN;
        else          state_d = KEY_WAIT;
      end
      RUN:     state_d = RUN;
      default: state_d = KEY_WAIT;
    endcase

    if (key_load) key_d = key_in;
    else          key_d = key_q;

    if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
    else        rd_ptr_d = rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s) begin
      if (dec_s[8]) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        else                    err_cnt_d = err_cnt_q;
      end else begin
        if (ok_cnt_q != 8'hFF) ok_cnt_d = ok_cnt_q + 8'd1;
        else                   ok_cnt_d = ok_cnt_q;
      end
    end else begin
      ok_cnt_d  = ok_cnt_q;
      err_cnt_d = err_cnt_q;
    end

    // A byte pushed into a FIFO that is (or becomes) empty is the new head.
    if (count_d == CW'(0)) begin
      head_s = 9'h000;
    end else if (push_s && (count_q == {{(CW-1){1'b0}}, pop_s})) begin
      head_s = dec_s;
    end else begin
      head_s = mem_q[rd_ptr_d];
    end

    in_ready_d  = (state_d == RUN) && (count_d < DEPTH_C);
    out_valid_d = (count_d != CW'(0));
    out_data_d  = head_s[7:0];
    out_err_d   = head_s[8];
  end

  // State, key, pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= KEY_WAIT;
      key_q       <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_err_q   <= 1'b0;
      ok_cnt_q    <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // FIFO storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= dec_s;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
